// File: rtl/itp_mem_pkg.sv
// Shared types and constants for the column-in / row-out transpose buffer.
package itp_mem_pkg;

    localparam int BW_DEFAULT = 8;
    localparam int BLK_DIM    = 8;

    typedef logic       bank_sel_t;
    typedef logic [2:0] idx_t;

endpackage

// File: rtl/itp_bank.sv
// One 8 x NCOL storage bank: a whole column is written per beat, a whole row is read out.
module itp_bank
    import itp_mem_pkg::*;
#(
    parameter int BW   = BW_DEFAULT,
    parameter int NCOL = 4
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  idx_t                  i_wcol,
    input  logic [BLK_DIM*BW-1:0] i_wdata,
    input  idx_t                  i_rrow,
    output logic [BLK_DIM*BW-1:0] o_rdata
);

    logic [BW-1:0] mem_q [BLK_DIM][NCOL];
    logic [BW-1:0] mem_d [BLK_DIM][NCOL];

    always_comb begin
        mem_d = mem_q;
        if (i_we) begin
            for (int r = 0; r < BLK_DIM; r++) begin
                for (int c = 0; c < NCOL; c++) begin
                    if (i_wcol == idx_t'(c)) begin
                        mem_d[r][c] = i_wdata[(BLK_DIM-1-r)*BW +: BW];
                    end
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        mem_q <= mem_d;
    end

    // Columns beyond NCOL are never stored and always read as zero.
    always_comb begin
        o_rdata = '0;
        for (int c = 0; c < NCOL; c++) begin
            o_rdata[(BLK_DIM-1-c)*BW +: BW] = mem_q[i_rrow][c];
        end
    end

endmodule

// File: rtl/itp_mem.sv
// Ping-pong transpose buffer: collects NCOL column beats per 8x8 block, then emits 8 rows.
// Define ITP_MEM_LAST_EN to add o_last, flagging row 7 of each block.
module itp_mem
    import itp_mem_pkg::*;
#(
    parameter int BW   = BW_DEFAULT,
    parameter int NCOL = 4
) (
    input  logic                  i_clk,
    input  logic                  i_Reset,
    input  logic [BLK_DIM*BW-1:0] i_data,
    input  logic                  i_valid,
    output logic                  o_ready,
    output logic [BLK_DIM*BW-1:0] o_data,
    output logic                  o_valid,
`ifdef ITP_MEM_LAST_EN
    output logic                  o_last,
`endif
    input  logic                  i_ready
);

    logic [1:0] full_q, full_d;
    bank_sel_t  wr_ptr_q, wr_ptr_d;
    bank_sel_t  rd_ptr_q, rd_ptr_d;
    idx_t       col_q, col_d;
    idx_t       row_q, row_d;
    logic       acc, cons;

    logic [BLK_DIM*BW-1:0] bank_rdata [2];

    assign o_ready = !full_q[wr_ptr_q];
    assign o_valid = full_q[rd_ptr_q];
    assign acc     = i_valid && o_ready;
    assign cons    = o_valid && i_ready;

    always_comb begin
        full_d   = full_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        col_d    = col_q;
        row_d    = row_q;
        if (acc) begin
            if (col_q == idx_t'(NCOL-1)) begin
                full_d[wr_ptr_q] = 1'b1;
                wr_ptr_d         = !wr_ptr_q;
                col_d            = '0;
            end else begin
                col_d = col_q + 3'd1;
            end
        end
        // Write and read always target different banks, so both updates can land together.
        if (cons) begin
            row_d = row_q + 3'd1;
            if (row_q == idx_t'(BLK_DIM-1)) begin
                full_d[rd_ptr_q] = 1'b0;
                rd_ptr_d         = !rd_ptr_q;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_Reset) begin
            full_q   <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            col_q    <= '0;
            row_q    <= '0;
        end else begin
            full_q   <= full_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            col_q    <= col_d;
            row_q    <= row_d;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        itp_bank #(
            .BW   (BW),
            .NCOL (NCOL)
        ) u_bank (
            .i_clk   (i_clk),
            .i_we    (acc && (wr_ptr_q == bank_sel_t'(b))),
            .i_wcol  (col_q),
            .i_wdata (i_data),
            .i_rrow  (row_q),
            .o_rdata (bank_rdata[b])
        );
    end

    // Stale bank contents survive reset, so mask the row whenever nothing is valid.
    assign o_data = o_valid ? bank_rdata[rd_ptr_q] : '0;

`ifdef ITP_MEM_LAST_EN
    assign o_last = o_valid && (row_q == idx_t'(BLK_DIM-1));
`endif

endmodule

// File: tb/tb_itp_mem.sv
// Scoreboard bench for itp_mem (BW=8, NCOL=4); checks o_last when ITP_MEM_LAST_EN is defined.
module tb_itp_mem;

    localparam int BW   = 8;
    localparam int NCOL = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] i_data;
    logic        i_valid;
    logic        o_ready;
    logic [63:0] o_data;
    logic        o_valid;
    logic        i_ready;
`ifdef ITP_MEM_LAST_EN
    logic        o_last;
`endif

    always #5 clk = ~clk;

    itp_mem #(.BW(BW), .NCOL(NCOL)) dut (
        .i_clk   (clk),
        .i_Reset (rst),
        .i_data  (i_data),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .o_data  (o_data),
        .o_valid (o_valid),
`ifdef ITP_MEM_LAST_EN
        .o_last  (o_last),
`endif
        .i_ready (i_ready)
    );

    int          checks = 0;
    int          errors = 0;
    logic [63:0] sb[$];
    bit          mon_en = 0;
    int          row_in_blk = 0;
    int          rows_seen = 0;

    function automatic logic [63:0] beat(int c, logic [7:0] tag);
        logic [63:0] v;
        for (int r = 0; r < 8; r++) v[(7-r)*8 +: 8] = 8'((r << 4) | c) + tag;
        return v;
    endfunction

    function automatic logic [63:0] exp_row(int r, logic [7:0] tag);
        logic [63:0] v;
        v = '0;
        for (int c = 0; c < NCOL; c++) v[(7-c)*8 +: 8] = 8'((r << 4) | c) + tag;
        return v;
    endfunction

    // Output monitor: pops the scoreboard on every consumed row
    always @(negedge clk) begin
        logic [63:0] exp_v;
        if (rst === 1'b1) begin
            row_in_blk = 0;
        end else if (mon_en) begin
            if (o_valid === 1'b1 && i_ready === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL row_unexpected got %h required none", o_data);
                end else begin
                    exp_v = sb.pop_front();
                    if (o_data !== exp_v) begin
                        errors++;
                        $display("FAIL row_data got %h required %h", o_data, exp_v);
                    end
                end
`ifdef ITP_MEM_LAST_EN
                checks++;
                if (o_last !== (row_in_blk == 7)) begin
                    errors++;
                    $display("FAIL o_last row %0d got %b required %b", row_in_blk, o_last, row_in_blk == 7);
                end
`endif
                row_in_blk = (row_in_blk + 1) % 8;
                rows_seen++;
            end else if (o_valid !== 1'b1) begin
                checks++;
                if (o_data !== 64'h0) begin
                    errors++;
                    $display("FAIL idle_data got %h required 0", o_data);
                end
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        i_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic send_beat(input logic [63:0] d);
        bit ok;
        ok = 0;
        i_valid = 1'b1;
        i_data = d;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (o_ready === 1'b1) begin
                ok = 1;
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
        end
        i_valid = 1'b0;
        if (!ok) begin
            errors++;
            $display("FAIL beat_timeout got o_ready=%b required 1", o_ready);
        end
    endtask

    task automatic push_block(input logic [7:0] tag);
        for (int r = 0; r < 8; r++) sb.push_back(exp_row(r, tag));
    endtask

    task automatic send_block(input logic [7:0] tag);
        for (int c = 0; c < NCOL; c++) send_beat(beat(c, tag));
        push_block(tag);
    endtask

    task automatic drain();
        for (int k = 0; k < 400; k++) begin
            if (sb.size() == 0) break;
            @(posedge clk); #1;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout got %0d rows pending required 0", sb.size());
        end
        @(posedge clk); #1;
        checks++;
        if (o_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_idle got o_valid=%b required 0", o_valid);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_o_valid got %b required 0", o_valid); end
        checks++;
        if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_o_ready got %b required 1", o_ready); end
        checks++;
        if (o_data !== 64'h0) begin errors++; $display("FAIL reset_o_data got %h required 0", o_data); end
`ifdef ITP_MEM_LAST_EN
        checks++;
        if (o_last !== 1'b0) begin errors++; $display("FAIL reset_o_last got %b required 0", o_last); end
`endif
    endtask

    task automatic test_single_block();
        i_ready = 1'b1;
        for (int c = 0; c < NCOL-1; c++) send_beat(beat(c, 8'h00));
        checks++;
        if (o_valid !== 1'b0) begin errors++; $display("FAIL early_valid got %b required 0", o_valid); end
        send_beat(beat(NCOL-1, 8'h00));
        checks++;
        if (o_valid !== 1'b1) begin errors++; $display("FAIL latency_valid got %b required 1", o_valid); end
        checks++;
        if (o_data !== 64'h0001020300000000) begin
            errors++;
            $display("FAIL latency_row0 got %h required %h", o_data, 64'h0001020300000000);
        end
        push_block(8'h00);
        drain();
    endtask

    task automatic test_backpressure();
        i_ready = 1'b0;
        send_block(8'h00);
        i_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        i_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (o_valid !== 1'b1 || o_data !== 64'h2021222300000000) begin
                errors++;
                $display("FAIL hold_row2 got v=%b %h required v=1 %h", o_valid, o_data, 64'h2021222300000000);
            end
            @(posedge clk); #1;
        end
        i_ready = 1'b1;
        drain();
    endtask

    task automatic test_two_banks();
        i_ready = 1'b0;
        send_block(8'h00);
        send_block(8'h40);
        checks++;
        if (o_ready !== 1'b0) begin errors++; $display("FAIL both_full_ready got %b required 0", o_ready); end
        i_valid = 1'b1;
        i_data = beat(0, 8'h20);
        i_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++;
            if (o_ready !== 1'b0) begin
                errors++;
                $display("FAIL held_off_ready cycle %0d got %b required 0", k, o_ready);
            end
            @(posedge clk);
        end
        @(negedge clk);
        checks++;
        if (o_ready !== 1'b1) begin errors++; $display("FAIL freed_ready got %b required 1", o_ready); end
        @(posedge clk); #1;
        i_valid = 1'b0;
        for (int c = 1; c < NCOL; c++) send_beat(beat(c, 8'h20));
        push_block(8'h20);
        drain();
    endtask

    task automatic test_reset_mid();
        i_ready = 1'b1;
        send_beat(beat(0, 8'h55));
        send_beat(beat(1, 8'h55));
        do_reset();
        checks++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_state got v=%b r=%b required v=0 r=1", o_valid, o_ready);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (o_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid got %b required 0", o_valid); end
        send_block(8'h08);
        drain();
    endtask

    task automatic test_streaming();
        int base;
        base = rows_seen;
        i_ready = 1'b1;
        send_block(8'h80);
        send_block(8'h04);
        send_block(8'h88);
        drain();
        checks++;
        if (rows_seen - base != 24) begin
            errors++;
            $display("FAIL stream_rows got %0d required 24", rows_seen - base);
        end
    endtask

    initial begin
        rst = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_data = '0;
        mon_en = 1;
        test_reset();
        test_single_block();
        test_backpressure();
        test_two_banks();
        test_reset_mid();
        test_streaming();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
